// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator with one shared prescaler and one shared period
// counter. Per-channel duty values and the period TOP are written into shadow
// registers. Their active copies reload only at a period boundary, so a period
// that is already running is never disturbed. While the block is disabled the
// active copies follow the shadows on every cycle.
//
// Optional feature (compile-time macro PWM_CENTER_ALIGN_EN):
//   When the macro is defined, CTRL bit1 selects center-aligned counting
//   (0..TOP up, then TOP-1..1 down). When the macro is undefined, CTRL bit1 is
//   accepted on write and then dropped, and only edge-aligned counting exists.
//
// Register map (wr_addr):
//   0..NCH-1 : duty shadow of channel i
//   13       : TOP shadow
//   14       : PRESC (takes effect on the next cycle)
//   15       : CTRL  bit0 enable, bit1 center mode
//   other    : ignored
//
// Ports:
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset, overrides wr_en
//   wr_en        : register write strobe
//   wr_addr      : register select
//   wr_data      : write data
//   pwm_out      : registered PWM outputs, bit i = channel i
//   period_start : one-cycle pulse, aligned with the first pwm_out of a period
// ---------------------------------------------------------------------------
module pwm_multi_channel #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_start
);

    localparam logic [3:0]       ADDR_TOP   = 4'd13;
    localparam logic [3:0]       ADDR_PRESC = 4'd14;
    localparam logic [3:0]       ADDR_CTRL  = 4'd15;
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    // Configuration registers
    logic [WIDTH-1:0] duty_sh_r  [NCH];
    logic [WIDTH-1:0] duty_act_r [NCH];
    logic [WIDTH-1:0] top_sh_r;
    logic [WIDTH-1:0] top_act_r;
    logic [WIDTH-1:0] presc_r;
    logic             en_r;
`ifdef PWM_CENTER_ALIGN_EN
    logic             center_r;
    logic             dir_down_r;
    logic             dir_down_nxt_s;
`endif

    // Counting state and outputs
    logic [WIDTH-1:0] presc_cnt_r;
    logic [WIDTH-1:0] cnt_r;
    logic [NCH-1:0]   pwm_r;
    logic             first_r;
    logic             period_start_r;

    // Combinational helpers
    logic [NCH-1:0]   duty_we_s;
    logic [NCH-1:0]   cmp_s;
    logic             top_we_s;
    logic             presc_we_s;
    logic             ctrl_we_s;
    logic             en_nxt_s;
    logic             run_s;
    logic             restart_s;
    logic             tick_s;
    logic             wrap_s;
    logic             boundary_s;
    logic [WIDTH-1:0] presc_nxt_s;
    logic [WIDTH-1:0] cnt_nxt_s;

    assign pwm_out      = pwm_r;
    assign period_start = period_start_r;

    // Register-write address decode
    always_comb begin
        duty_we_s = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_we_s[i] = wr_en && (wr_addr == 4'(i));
        end
        top_we_s   = wr_en && (wr_addr == ADDR_TOP);
        presc_we_s = wr_en && (wr_addr == ADDR_PRESC);
        ctrl_we_s  = wr_en && (wr_addr == ADDR_CTRL);
    end

    // Run qualification: counting happens only when enable is set now and
    // stays set after this edge, so an enabling write starts from zero and a
    // disabling write clears the outputs on the very next cycle.
    always_comb begin
        en_nxt_s  = en_r;
        restart_s = 1'b0;
        if (ctrl_we_s) begin
            en_nxt_s = wr_data[0];
        end else begin
            en_nxt_s = en_r;
        end
        run_s = en_r && en_nxt_s;
`ifdef PWM_CENTER_ALIGN_EN
        restart_s = ctrl_we_s && (wr_data[1] != center_r);
`endif
    end

    // Prescaler tick and counter next-state
    always_comb begin
        tick_s      = (presc_cnt_r >= presc_r);
        presc_nxt_s = presc_cnt_r + ONE;
        cnt_nxt_s   = cnt_r;
        wrap_s      = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_nxt_s = dir_down_r;
`endif
        if (tick_s) begin
            presc_nxt_s = '0;
`ifdef PWM_CENTER_ALIGN_EN
            if (center_r) begin
                if (dir_down_r) begin
                    // Down leg ends at 1; reload to 0 closes the period.
                    if (cnt_r <= ONE) begin
                        cnt_nxt_s      = '0;
                        dir_down_nxt_s = 1'b0;
                        wrap_s         = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - ONE;
                    end
                end else if (cnt_r >= top_act_r) begin
                    // TOP of 0 or 1 has no down leg: reload straight from TOP.
                    if (top_act_r <= ONE) begin
                        cnt_nxt_s = '0;
                        wrap_s    = 1'b1;
                    end else begin
                        cnt_nxt_s      = cnt_r - ONE;
                        dir_down_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + ONE;
                end
            end else if (cnt_r >= top_act_r) begin
                cnt_nxt_s = '0;
                wrap_s    = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
`else
            if (cnt_r >= top_act_r) begin
                cnt_nxt_s = '0;
                wrap_s    = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
`endif
        end else begin
            presc_nxt_s = presc_cnt_r + ONE;
        end
        boundary_s = run_s && !restart_s && wrap_s;
    end

    // Per-channel compare against the active duty
    always_comb begin
        cmp_s = '0;
        for (int i = 0; i < NCH; i++) begin
            cmp_s[i] = (cnt_r < duty_act_r[i]);
        end
    end

    // Shadow, prescaler and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                duty_sh_r[i] <= '0;
            end
            top_sh_r <= '1;
            presc_r  <= '0;
            en_r     <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            center_r <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (duty_we_s[i]) begin
                    duty_sh_r[i] <= wr_data;
                end
            end
            if (top_we_s) begin
                top_sh_r <= wr_data;
            end
            if (presc_we_s) begin
                presc_r <= wr_data;
            end
            if (ctrl_we_s) begin
                en_r <= wr_data[0];
`ifdef PWM_CENTER_ALIGN_EN
                center_r <= wr_data[1];
`endif
            end
        end
    end

    // Active copies: follow shadows while idle, reload at a period boundary.
    // The shadow is read before any same-edge write lands, so a write on the
    // boundary cycle waits for the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act_r[i] <= '0;
            end
            top_act_r <= '1;
        end else if (!run_s || boundary_s) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act_r[i] <= duty_sh_r[i];
            end
            top_act_r <= top_sh_r;
        end else begin
            top_act_r <= top_act_r;
        end
    end

    // Prescaler, counter and registered outputs. first_r marks the cycle in
    // which the counter holds 0 after a reload; period_start follows it by one
    // cycle so it lines up with the pwm_out produced from that counter value.
    always_ff @(posedge clk) begin
        if (rst || !run_s) begin
            presc_cnt_r    <= '0;
            cnt_r          <= '0;
            pwm_r          <= '0;
            first_r        <= 1'b0;
            period_start_r <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r     <= 1'b0;
`endif
        end else if (restart_s) begin
            presc_cnt_r    <= '0;
            cnt_r          <= '0;
            pwm_r          <= cmp_s;
            first_r        <= 1'b0;
            period_start_r <= first_r;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r     <= 1'b0;
`endif
        end else begin
            presc_cnt_r    <= presc_nxt_s;
            cnt_r          <= cnt_nxt_s;
            pwm_r          <= cmp_s;
            first_r        <= boundary_s;
            period_start_r <= first_r;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r     <= dir_down_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Self-checking bench for pwm_multi_channel (NCH=4, WIDTH=8). A reference
// model tracks the elapsed cycles within the current period and derives the
// counter value from that position arithmetically. A compare process checks
// pwm_out and period_start on every cycle. Directed scenarios pin the model
// with hand-computed period lengths and high-time counts, and a randomized
// phase follows them.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [NCH-1:0]   pwm_out;
    logic             period_start;

    int n_checks;
    int n_err;

    // reference model state
    bit             model_valid;
    bit             m_en;
    bit             m_center;
    int             m_presc;
    int             m_top_sh;
    int             m_top_act;
    int             m_duty_sh  [NCH];
    int             m_duty_act [NCH];
    int             m_e;      // cycles elapsed in current period
    int             m_nper;   // reloads seen since counting started
    logic [NCH-1:0] exp_pwm;
    logic           exp_ps;

    // measurement results
    int meas_len;
    int meas_hi [NCH];

    pwm_multi_channel #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ticks_per_period(input int top, input bit ctr);
        if (ctr) return (top == 0) ? 1 : 2 * top;
        return top + 1;
    endfunction

    function automatic int count_at(input int e, input int presc, input int top, input bit ctr);
        int t;
        t = e / (presc + 1);
        if (ctr && t > top) return 2 * top - t;
        return t;
    endfunction

    task automatic model_step();
        bit wc;
        bit en_n;
        bit run;
        bit restart;
        int cv;
        int len;
        if (rst) begin
            model_valid = 1'b1;
            m_en = 1'b0; m_center = 1'b0; m_presc = 0;
            m_top_sh = 255; m_top_act = 255;
            for (int i = 0; i < NCH; i++) begin
                m_duty_sh[i] = 0; m_duty_act[i] = 0;
            end
            m_e = 0; m_nper = 0; exp_pwm = '0; exp_ps = 1'b0;
            return;
        end
        wc      = wr_en && (wr_addr == 4'd15);
        en_n    = wc ? wr_data[0] : m_en;
        run     = m_en && en_n;
        restart = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        restart = wc && (wr_data[1] != m_center);
`endif
        if (!run) begin
            exp_pwm = '0; exp_ps = 1'b0; m_e = 0; m_nper = 0;
            m_top_act = m_top_sh;
            for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
        end else begin
            cv = count_at(m_e, m_presc, m_top_act, m_center);
            for (int i = 0; i < NCH; i++) exp_pwm[i] = (cv < m_duty_act[i]);
            exp_ps = (m_e == 0) && (m_nper > 0);
            if (restart) begin
                m_e = 0; m_nper = 0;
            end else begin
                len = ticks_per_period(m_top_act, m_center) * (m_presc + 1);
                m_e++;
                if (m_e >= len) begin
                    m_e = 0; m_nper++;
                    m_top_act = m_top_sh;
                    for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
                end
            end
        end
        if (wr_en) begin
            if (wr_addr < 4'(NCH)) m_duty_sh[wr_addr] = int'(wr_data);
            else if (wr_addr == 4'd13) m_top_sh = int'(wr_data);
            else if (wr_addr == 4'd14) m_presc = int'(wr_data);
            else if (wr_addr == 4'd15) begin
                m_en = wr_data[0];
`ifdef PWM_CENTER_ALIGN_EN
                m_center = wr_data[1];
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            n_checks++;
            if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t: pwm_out=%b period_start=%b, expected pwm_out=%b period_start=%b",
                         $time, pwm_out, period_start, exp_pwm, exp_ps);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // caller is at a negedge; the write is sampled at the next posedge
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_first_ps(input string name, input int exp);
        int c;
        c = 0;
        while (period_start !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(name, c, exp);
    endtask

    // One full period from a period_start to the next; optional write at an
    // offset inside the window.
    task automatic measure(input int wr_off, input logic [3:0] a, input logic [7:0] d);
        int c;
        c = 0;
        while (period_start !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) begin
            chk("period_start_timeout", 0, 1);
        end
        meas_len = 0;
        for (int i = 0; i < NCH; i++) meas_hi[i] = 0;
        do begin
            for (int i = 0; i < NCH; i++) meas_hi[i] += int'(pwm_out[i]);
            if (meas_len == wr_off) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            meas_len++;
        end while (period_start !== 1'b1 && meas_len < 3000);
        wr_en = 1'b0;
    endtask

    initial begin
        int top;
        int pr;
        int r;
        n_checks = 0; n_err = 0; model_valid = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_period_start", int'(period_start), 0);
        rst = 1'b0;

        // edge mode, four duty cases
        wr(4'd13, 8'd9); wr(4'd0, 8'd3); wr(4'd1, 8'd0); wr(4'd2, 8'd10); wr(4'd3, 8'd9);
        wr(4'd15, 8'd1);
        wait_first_ps("edge_first_ps", 11);
        measure(-1, 4'd0, 8'd0);
        chk("edge_period", meas_len, 10);
        chk("edge_ch0_hi", meas_hi[0], 3);
        chk("edge_ch1_hi", meas_hi[1], 0);
        chk("edge_ch2_hi", meas_hi[2], 10);
        chk("edge_ch3_hi", meas_hi[3], 9);

        // shadow: mid-period write, then boundary-cycle write
        measure(4, 4'd0, 8'd7);
        chk("shadow_mid_same", meas_hi[0], 3);
        measure(-1, 4'd0, 8'd0);
        chk("shadow_mid_next", meas_hi[0], 7);
        measure(8, 4'd0, 8'd5);
        chk("shadow_bnd_same", meas_hi[0], 7);
        measure(-1, 4'd0, 8'd0);
        chk("shadow_bnd_next", meas_hi[0], 7);
        measure(-1, 4'd0, 8'd0);
        chk("shadow_bnd_later", meas_hi[0], 5);

        // disable clears outputs next cycle; prescaler with restart from 0
        wr(4'd15, 8'd0);
        chk("disable_pwm", int'(pwm_out), 0);
        wr(4'd0, 8'd3); wr(4'd14, 8'd2); wr(4'd15, 8'd1);
        wait_first_ps("presc_first_ps", 31);
        measure(-1, 4'd0, 8'd0);
        chk("presc_period", meas_len, 30);
        chk("presc_ch0_hi", meas_hi[0], 9);
        chk("presc_ch3_hi", meas_hi[3], 27);

        // mid-run reset with a competing write
        repeat (7) @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'd1;
        repeat (2) @(negedge clk);
        wr_en = 1'b0; rst = 1'b0;
        chk("midreset_pwm", int'(pwm_out), 0);
        chk("midreset_ps", int'(period_start), 0);
        wr(4'd15, 8'd1);
        wait_first_ps("reset_first_ps", 257);
        measure(-1, 4'd0, 8'd0);
        chk("reset_period", meas_len, 256);
        chk("reset_hi_all", meas_hi[0] + meas_hi[1] + meas_hi[2] + meas_hi[3], 0);

        // center request
        wr(4'd15, 8'd0); wr(4'd13, 8'd4); wr(4'd0, 8'd2); wr(4'd15, 8'd3);
        measure(-1, 4'd0, 8'd0);
`ifdef PWM_CENTER_ALIGN_EN
        chk("center_period", meas_len, 8);
        chk("center_ch0_hi", meas_hi[0], 3);
`else
        chk("center_off_period", meas_len, 5);
        chk("center_off_ch0_hi", meas_hi[0], 2);
`endif

        // randomized phase
        for (int it = 0; it < 25; it++) begin
            wr(4'd15, 8'd0);
            top = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 14));
            pr  = int'($urandom_range(0, 3));
            wr(4'd13, 8'(top)); wr(4'd14, 8'(pr));
            for (int i = 0; i < NCH; i++) wr(4'(i), 8'($urandom_range(0, top + 2)));
            wr(4'd15, 8'($urandom_range(0, 1) * 2 + 1));
            for (int k = 0; k < 150; k++) begin
                r = int'($urandom_range(0, 9));
                rst = (k == 75 && (it % 7) == 3);
                if (r < 3) begin
                    wr_en = 1'b1;
                    wr_addr = 4'($urandom_range(0, 13));
                    wr_data = 8'($urandom_range(0, 16));
                end else begin
                    wr_en = 1'b0;
                end
                @(negedge clk);
            end
            wr_en = 1'b0; rst = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PWM channels (legal 1..12).
REQ-002 SHALL have parameter WIDTH, default 8, counter/duty/period width (legal 4..16).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-006 SHALL have port wr_addr  input  4  register select.
REQ-007 SHALL have port wr_data  input  WIDTH  write data.
REQ-008 SHALL have port pwm_out  output  NCH  registered PWM outputs, bit i = channel i.
REQ-009 SHALL have port period_start  output  1  one-cycle pulse on counter reload.

Function
REQ-010 Register map SHALL be: 0..NCH-1 duty shadow of channel; 13 TOP shadow; 14 PRESC; 15 CTRL (bit0 enable, bit1 center mode); addresses NCH..12 ignored.
REQ-011 Prescaler SHALL count 0..PRESC and assert internal tick when equal to PRESC, then restart at 0; PRESC=0 ticks every cycle.
REQ-012 Edge mode: counter SHALL increment on tick 0..TOP_active, wrap to 0 on tick at TOP_active; period = (TOP+1)*(PRESC+1) cycles.
REQ-013 Compare SHALL be cnt < duty_active[i]; duty=0 gives constant low, duty>TOP gives constant high.
REQ-014 pwm_out SHALL be registered: one cycle latency from counter value to output.
REQ-015 Period boundary = tick cycle where counter reloads to 0; period_start SHALL pulse the cycle after, aligned with first pwm_out of new period.
REQ-016 duty and TOP writes SHALL land in shadow registers; active copies SHALL load from shadow only at period boundary.
REQ-017 Write coinciding with boundary: active SHALL load pre-write shadow value; new value takes effect at following boundary.
REQ-018 PRESC and CTRL writes SHALL take effect next cycle.
REQ-019 While enable=0: prescaler and counter held at 0, direction up, pwm_out all 0, period_start 0, active copies track shadows every cycle.
REQ-020 Enable 0->1: counting SHALL start from 0 next cycle with first period_start pulse after first reload.
REQ-021 Any CTRL write changing bit1 SHALL restart prescaler and counter at 0, direction up.
REQ-022 TOP=0 SHALL be legal: every tick is a boundary; edge-mode channel with duty>=1 constant high.

Reset
REQ-023 rst high SHALL set: pwm_out=0, period_start=0, counter=0, prescaler=0, direction up, all duty shadow/active=0, TOP shadow/active=all ones, PRESC=0, CTRL=0.
REQ-024 rst SHALL override wr_en in the same cycle; reset mid-period SHALL abort the period with outputs low next cycle.

Configuration
REQ-025 Macro PWM_CENTER_ALIGN_EN SHALL compile in center-aligned mode.
REQ-026 With macro, CTRL bit1=1: counter SHALL count up 0..TOP then down TOP-1..1, period 2*TOP ticks (TOP=0: 1 tick); boundary at reload to 0 from 1 (or from TOP when TOP<=1).
REQ-027 Without macro: CTRL bit1 SHALL be stored-as-ignored, no down-count logic present, behaviour identical to edge mode, REQ-021 restart not triggered.

Verification (NCH=4, WIDTH=8)
REQ-028 Reset: hold rst 2 cycles mid-run -> pwm_out=0000, period_start=0, then with enable only: all channels low, period_start every 256 cycles.
REQ-029 Edge: TOP=9, duty0=3, duty1=0, duty2=10, duty3=9, enable -> ch0 high 3/10, ch1 never, ch2 always, ch3 9/10; period_start every 10 cycles.
REQ-030 Shadow: at cycle 4 of a period write duty0=7 -> ch0 stays 3/10 rest of period, 7/10 from next period_start; write on boundary cycle delays one extra period.
REQ-031 Prescaler: TOP=9, PRESC=2, duty0=3 -> period_start every 30 cycles, ch0 high 9 consecutive cycles.
REQ-032 Center (macro on): TOP=4, duty0=2, CTRL=3 -> counter 0,1,2,3,4,3,2,1 repeating, ch0 high 3/8 ticks, period_start every 8 cycles; macro off same stimulus -> 2/5 edge behaviour.
REQ-033 Disable mid-period: CTRL=0 -> pwm_out=0000 next cycle; re-enable -> counter restarts at 0.
